// File: rtl/noc_ctrl_pkg.sv
// Shared NoC control types: arbiter FSM states and the source-index width helper.
package noc_ctrl_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Width of an index over n items; never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry in-order buffer with a registered free-slot flag, so upstream
// ready never depends combinationally on downstream ready.
module axis_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  logic [W-1:0] mem [2];
  logic         wr, rd;
  logic [1:0]   cnt, cnt_nxt;
  logic         free;
  logic         push, pop;

  assign push      = in_valid & free;
  assign pop       = out_valid & out_ready;
  assign out_valid = (cnt != 2'd0);
  assign out_data  = mem[rd];
  assign in_ready  = free;

  always_comb begin
    cnt_nxt = cnt;
    case ({push, pop})
      2'b10:   cnt_nxt = cnt + 2'd1;
      2'b01:   cnt_nxt = cnt - 2'd1;
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem  <= '{default: '0};
      wr   <= 1'b0;
      rd   <= 1'b0;
      cnt  <= 2'd0;
      free <= 1'b1;
    end else begin
      cnt  <= cnt_nxt;
      // Look-ahead on the next occupancy keeps the flag registered yet exact.
      free <= (cnt_nxt != 2'd2);
      if (push) begin
        mem[wr] <= in_data;
        wr      <= ~wr;
      end
      if (pop) rd <= ~rd;
    end
  end

endmodule

// File: rtl/axis_inject_arbiter.sv
// Packet-atomic round-robin arbiter merging NUM_SRC AXI-Stream sources onto
// one mesh injection port through a two-entry skid buffer.
module axis_inject_arbiter
  import noc_ctrl_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int TID_WIDTH   = 2,
  parameter int TDEST_WIDTH = 4,
  parameter int TDATA_WIDTH = 512
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_tvalid [NUM_SRC],
  input  logic                   s_tlast  [NUM_SRC],
  input  logic [TDATA_WIDTH-1:0] s_tdata  [NUM_SRC],
  input  logic [TDEST_WIDTH-1:0] s_tdest  [NUM_SRC],
  output logic                   s_tready [NUM_SRC],
  input  logic [NUM_SRC-1:0]     src_enable,
  output logic                   m_tvalid,
  output logic                   m_tlast,
  input  logic                   m_tready,
  output logic [TDATA_WIDTH-1:0] m_tdata,
  output logic [TDEST_WIDTH-1:0] m_tdest,
  output logic [TID_WIDTH-1:0]   m_tid,
  output logic                   busy
);

  localparam int IW = idx_w(NUM_SRC);
  localparam int PW = TDATA_WIDTH + TDEST_WIDTH + TID_WIDTH + 1;

  if (TID_WIDTH < $clog2(NUM_SRC)) begin : g_tid_chk
    $error("axis_inject_arbiter: TID_WIDTH too narrow for NUM_SRC");
  end

  arb_state_e     state, state_nxt;
  logic [IW-1:0]  ptr, ptr_nxt, g, g_nxt;
  logic [IW-1:0]  win, sel;
  logic           win_found, sel_ok, free, accept;
  logic [TID_WIDTH-1:0] tid_in;
  logic [PW-1:0]  in_data, out_data;

  function automatic logic [IW-1:0] nxt_idx(input logic [IW-1:0] x);
    return (int'(x) == NUM_SRC - 1) ? '0 : x + IW'(1);
  endfunction

  // Round-robin search starting at ptr.
  always_comb begin
    int j;
    win_found = 1'b0;
    win       = ptr;
    for (int k = 0; k < NUM_SRC; k++) begin
      j = (int'(ptr) + k) % NUM_SRC;
      if (!win_found && s_tvalid[j] && src_enable[j]) begin
        win_found = 1'b1;
        win       = IW'(j);
      end
    end
  end

  assign sel    = (state == ARB_LOCKED) ? g : win;
  assign sel_ok = (state == ARB_LOCKED) | win_found;
  assign accept = sel_ok & free & ~rst & s_tvalid[sel];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_rdy
    assign s_tready[i] = sel_ok & free & ~rst & (sel == IW'(i));
  end

  always_comb begin
    state_nxt = state;
    g_nxt     = g;
    ptr_nxt   = ptr;
    if (accept) begin
      if (state == ARB_IDLE) begin
        if (s_tlast[sel]) ptr_nxt = nxt_idx(win);
        else begin
          state_nxt = ARB_LOCKED;
          g_nxt     = win;
        end
      end else if (s_tlast[sel]) begin
        state_nxt = ARB_IDLE;
        ptr_nxt   = nxt_idx(g);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
      g     <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      g     <= g_nxt;
      ptr   <= ptr_nxt;
    end
  end

  assign tid_in  = TID_WIDTH'(sel);
  assign in_data = {s_tlast[sel], tid_in, s_tdest[sel], s_tdata[sel]};

  axis_skid_buffer #(.W(PW)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept),
    .in_data   (in_data),
    .in_ready  (free),
    .out_valid (m_tvalid),
    .out_data  (out_data),
    .out_ready (m_tready)
  );

  assign {m_tlast, m_tid, m_tdest, m_tdata} = out_data;
  assign busy = (state == ARB_LOCKED) | m_tvalid;

endmodule

// File: doc/axis_inject_arbiter.md
AXIS_INJECT_ARBITER -- requirements
Module: axis_inject_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4: number of AXI-Stream requesters sharing one mesh injection port.
REQ-002 SHALL have parameter TID_WIDTH, default 2: output tid width; elaboration error if < $clog2(NUM_SRC).
REQ-003 SHALL have parameter TDEST_WIDTH, default 4: tdest width, passed through unchanged.
REQ-004 SHALL have parameter TDATA_WIDTH, default 512: tdata width, passed through unchanged.
REQ-005 SHALL have port clk, input, 1 bit: single clock; one clock; reset is synchronous and active-high.
REQ-006 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL have ports s_tvalid, s_tlast, input, unpacked [NUM_SRC] x 1 bit: per-source valid and last.
REQ-008 SHALL have port s_tdata, input, [NUM_SRC] x TDATA_WIDTH: per-source data.
REQ-009 SHALL have port s_tdest, input, [NUM_SRC] x TDEST_WIDTH: per-source destination.
REQ-010 SHALL have port s_tready, output, [NUM_SRC] x 1 bit: per-source ready.
REQ-011 SHALL have port src_enable, input, NUM_SRC bits: sources eligible for new grants.
REQ-012 SHALL have port m_tvalid, m_tlast, output, 1 bit each: injection-side valid and last.
REQ-013 SHALL have port m_tready, input, 1 bit: injection-side ready.
REQ-014 SHALL have ports m_tdata (TDATA_WIDTH), m_tdest (TDEST_WIDTH), m_tid (TID_WIDTH), all outputs; m_tid carries the zero-extended source index.
REQ-015 SHALL have port busy, output, 1 bit: high in LOCKED or when the skid buffer is non-empty.

Function
REQ-016 SHALL use a two-state FSM: IDLE (no owner) and LOCKED (owner g).
REQ-017 IDLE: the winner is the first index i, searched from ptr upward modulo NUM_SRC, with s_tvalid[i] & src_enable[i]; only s_tready[winner] may be high.
REQ-018 IDLE: accepting the winner's beat with tlast=0 SHALL go to LOCKED with g=winner; with tlast=1 it SHALL stay IDLE and set ptr=(winner+1) mod NUM_SRC.
REQ-019 LOCKED: only s_tready[g] may be high, and src_enable SHALL be ignored, so a packet is never broken.
REQ-020 LOCKED: accepting a beat with tlast=1 SHALL go to IDLE and set ptr=(g+1) mod NUM_SRC.
REQ-021 The granted source's s_tready SHALL equal the registered "skid buffer has a free slot" flag; no combinational path from m_tready to s_tready.
REQ-022 An accepted beat SHALL appear on m_* exactly 1 cycle later if the skid buffer is empty; sustained throughput SHALL be 1 beat/cycle, with no bubble between back-to-back packets.
REQ-023 The skid buffer SHALL have 2 entries and be in-order; m_* SHALL hold stable while m_tvalid=1 and m_tready=0.
REQ-024 No requester eligible, or buffer full: all s_tready=0 and the state is unchanged.
REQ-025 Pointer wrap: with ptr=NUM_SRC-1, a grant to NUM_SRC-1 SHALL set ptr=0.
REQ-026 Simultaneous buffer push and pop at occupancy 2 SHALL NOT occur, because ready is low; at occupancy 1, push+pop SHALL keep occupancy 1.

Reset
REQ-027 rst SHALL force: state=IDLE, ptr=0, skid buffer empty, m_tvalid=0, busy=0, all s_tready=0, and tdata/tdest/tid/tlast=0 in the cycle following reset.
REQ-028 rst mid-packet SHALL drop buffered beats; the truncated packet is not completed, and the upstream is responsible for resetting concurrently.

Structure
REQ-029 The FSM state enum and the ptr/tid width helper SHALL live in the shared noc_ctrl_pkg.
REQ-030 The 2-entry buffer SHALL be the sub-module axis_skid_buffer, parameterised by payload width (TDATA_WIDTH+TDEST_WIDTH+TID_WIDTH+1).

Verification
REQ-031 Sources 0 and 2 each send a 3-beat packet, both valid at cycle 0, ptr=0, m_tready=1 -> src0 beats at cycles 1-3 with tid=0, src2 beats at cycles 4-6 with tid=2, and no interleaving.
REQ-032 All 4 sources stream 1-beat packets continuously -> m_tid sequence 0,1,2,3,0,... at 1 beat/cycle.
REQ-033 src_enable[1] dropped during the 2nd beat of a 4-beat src1 packet -> all 4 beats complete, and src1 receives no grant afterwards.
REQ-034 m_tready=0 for 5 cycles mid-packet -> at most 2 beats buffered, s_tready drops, m_* stable, and no data loss or duplication.
REQ-035 rst asserted during beat 2 of a 4-beat packet -> next cycle m_tvalid=0, busy=0, and the next grant goes to the lowest-index valid enabled source.
